receptor_sync: RTL and testbench

- Receive-side counterpart of the VGA timing generator: takes active-low h_sync/v_sync plus the pixel clock and recovers pixel coordinates and video_on.
- Checks every line and frame against nominal 640x480@60 timing, and reports lock and timing errors.
- Sits in the capture/self-check path: loopback verification of the generator, or the front end of a frame-capture block.

---
 rtl/receptor_sync_pkg.sv | 42 ++++
 rtl/receptor_sync_edge_det.sv | 37 +++
 rtl/receptor_sync.sv | 183 ++++++++++++++++++
 tb/tb_receptor_sync.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/receptor_sync_pkg.sv
// Shared definitions for the sync receptor: FSM encoding, 640x480@60 timing
// defaults (same numbers the VGA generator uses) and a saturating counter helper.
package receptor_sync_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  // Nominal 640x480@60 timing
  localparam int VGA_H_DISP  = 640;
  localparam int VGA_H_FP    = 16;
  localparam int VGA_H_SYNC  = 96;
  localparam int VGA_H_BP    = 48;
  localparam int VGA_V_DISP  = 480;
  localparam int VGA_V_FP    = 10;
  localparam int VGA_V_SYNC  = 2;
  localparam int VGA_V_BP    = 33;

  // Derived totals and sync-start positions
  localparam int VGA_H_TOTAL = VGA_H_DISP + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_DISP + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int VGA_H_SS    = VGA_H_DISP + VGA_H_FP;
  localparam int VGA_V_SS    = VGA_V_DISP + VGA_V_FP;

  // Counter widths used on the ports
  localparam int CNT_W = 10;
  localparam int ERR_W = 8;

  // Increment an 8-bit count, holding at all-ones instead of wrapping
  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    logic [7:0] res;
    if (val == 8'hFF) begin
      res = val;
    end else begin
      res = val + 8'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/receptor_sync_edge_det.sv
// Single-register sampler for one active-low sync input. The sample resets
// high (idle level) so the first real assertion after reset reads as a fall.
// fall/rise compare the stored sample with the live input and are only ever
// consumed by registers in the parent.
module sync_edge_det
  import receptor_sync_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic sync_in,
  output logic sample,
  output logic fall,
  output logic rise
);

  logic sample_d;
  logic sample_q;

  // Next sample is simply the current input level
  always_comb begin
    sample_d = sync_in;
  end

  // Input sample register, idle-high after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q <= 1'b1;
    end else begin
      sample_q <= sample_d;
    end
  end

  assign sample = sample_q;
  assign fall   = sample_q & ~sync_in;
  assign rise   = ~sample_q & sync_in;

endmodule

// File: rtl/receptor_sync.sv
// Sync receptor: recovers pixel coordinates from active-low h/v sync, checks
// every line and frame against the nominal timing and reports lock/errors.
// Counters run freely and are re-aligned by sync falling edges in every state;
// timing checks only run once a first vsync has aligned the counters.
module receptor_sync
  import receptor_sync_pkg::*;
#(
  parameter int H_DISP = VGA_H_DISP,
  parameter int H_FP   = VGA_H_FP,
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BP   = VGA_H_BP,
  parameter int V_DISP = VGA_V_DISP,
  parameter int V_FP   = VGA_V_FP,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BP   = VGA_V_BP
) (
  input  logic       CLK_pix_rate,
  input  logic       reset,
  input  logic       h_sync_in,
  input  logic       v_sync_in,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       locked,
  output logic       frame_start,
  output logic       err,
  output logic [7:0] err_cnt
);

  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int H_SS    = H_DISP + H_FP;
  localparam int V_SS    = V_DISP + V_FP;

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SS_C    = 10'(H_SS);
  localparam logic [9:0] H_FALL_AT = 10'(H_SS - 1);
  localparam logic [9:0] H_RISE_AT = 10'(H_SS + H_SYNC - 1);
  localparam logic [9:0] V_SS_C    = 10'(V_SS);
  localparam logic [9:0] V_FALL_AT = 10'(V_SS - 1);
  localparam logic [9:0] V_END_C   = 10'(V_SS + V_SYNC);
  localparam logic [9:0] H_DISP_C  = 10'(H_DISP);
  localparam logic [9:0] V_DISP_C  = 10'(V_DISP);

  logic h_q, h_fall, h_rise;
  logic v_q, v_fall, v_rise_unused;

  logic [9:0] h_cnt_d, h_cnt_q;
  logic [9:0] v_cnt_d, v_cnt_q;
  state_e     state_d, state_q;
  logic       viol;
  logic       err_d, err_q;
  logic [7:0] err_cnt_d, err_cnt_q;
  logic       locked_d, locked_q;
  logic       video_on_d, video_on_q;
  logic       frame_start_d, frame_start_q;

  sync_edge_det u_h_det (
    .clk     (CLK_pix_rate),
    .rst_n   (reset),
    .sync_in (h_sync_in),
    .sample  (h_q),
    .fall    (h_fall),
    .rise    (h_rise)
  );

  sync_edge_det u_v_det (
    .clk     (CLK_pix_rate),
    .rst_n   (reset),
    .sync_in (v_sync_in),
    .sample  (v_q),
    .fall    (v_fall),
    .rise    (v_rise_unused)
  );

  // Free-running position counters with sync-edge alignment loads (vsync wins)
  always_comb begin
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = 10'd0;
      if (v_cnt_q == V_LAST) begin
        v_cnt_d = 10'd0;
      end else begin
        v_cnt_d = v_cnt_q + 10'd1;
      end
    end else begin
      h_cnt_d = h_cnt_q + 10'd1;
    end
    if (h_fall) begin
      h_cnt_d = H_SS_C;
    end else begin
      h_cnt_d = h_cnt_d;
    end
    if (v_fall) begin
      v_cnt_d = V_SS_C;
      h_cnt_d = 10'd0;
    end else begin
      v_cnt_d = v_cnt_d;
    end
  end

  // Timing checks against the current counter and sample registers
  always_comb begin
    viol = 1'b0;
    if (state_q != ST_SEARCH) begin
      viol = (h_fall && (h_cnt_q != H_FALL_AT))
          || (h_rise && (h_cnt_q != H_RISE_AT))
          || ((h_cnt_q == H_SS_C) && h_q)
          || (v_fall && ((v_cnt_q != V_FALL_AT) || (h_cnt_q != H_LAST)))
          || ((v_cnt_q == V_END_C) && (h_cnt_q == 10'd0) && !v_q)
          || ((v_cnt_q == V_SS_C) && (h_cnt_q == 10'd1) && v_q);
    end else begin
      viol = 1'b0;
    end
  end

  // Lock FSM next state and decode of the next output values
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SEARCH: begin
        if (v_fall) state_d = ST_CHECK;
        else        state_d = ST_SEARCH;
      end
      ST_CHECK: begin
        if (viol)        state_d = ST_SEARCH;
        else if (v_fall) state_d = ST_LOCKED;
        else             state_d = ST_CHECK;
      end
      ST_LOCKED: begin
        if (viol) state_d = ST_SEARCH;
        else      state_d = ST_LOCKED;
      end
      default: state_d = ST_SEARCH;
    endcase
    // Only a violation seen while locked counts as an error; CHECK just falls back
    err_d         = (state_q == ST_LOCKED) && viol;
    err_cnt_d     = err_d ? sat_inc8(err_cnt_q) : err_cnt_q;
    locked_d      = (state_d == ST_LOCKED);
    video_on_d    = locked_d && (h_cnt_d < H_DISP_C) && (v_cnt_d < V_DISP_C);
    frame_start_d = locked_d && (h_cnt_d == 10'd0) && (v_cnt_d == 10'd0);
  end

  // Position counter registers
  always_ff @(posedge CLK_pix_rate or negedge reset) begin
    if (!reset) begin
      h_cnt_q <= 10'd0;
      v_cnt_q <= 10'd0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Lock FSM state and its registered outputs
  always_ff @(posedge CLK_pix_rate or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_SEARCH;
      err_q         <= 1'b0;
      err_cnt_q     <= 8'd0;
      locked_q      <= 1'b0;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      err_q         <= err_d;
      err_cnt_q     <= err_cnt_d;
      locked_q      <= locked_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pixel_x     = h_cnt_q;
  assign pixel_y     = v_cnt_q;
  assign video_on    = video_on_q;
  assign locked      = locked_q;
  assign frame_start = frame_start_q;
  assign err         = err_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_receptor_sync.sv
// Directed bench for receptor_sync, run with a shrunken 8x8 raster so that
// locking, fault injection and 300 relocks stay short.
// Raster: H 4+1+2+1 (hsync low at x=5..6), V 3+1+2+2 (vsync low at y=4..5).
module tb_receptor_sync;

  localparam int H_DISP  = 4;
  localparam int H_FP    = 1;
  localparam int H_SYNC  = 2;
  localparam int H_BP    = 1;
  localparam int V_DISP  = 3;
  localparam int V_FP    = 1;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 2;
  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int H_SS    = H_DISP + H_FP;
  localparam int V_SS    = V_DISP + V_FP;

  localparam int F_NONE   = 0;
  localparam int F_HSHIFT = 1;
  localparam int F_HOMIT  = 2;
  localparam int F_VLONG  = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       h_sync_in;
  logic       v_sync_in;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       video_on;
  logic       locked;
  logic       frame_start;
  logic       err;
  logic [7:0] err_cnt;

  int checks   = 0;
  int errors   = 0;
  int bx       = 0;
  int by       = 0;
  int lx       = 0;
  int ly       = 0;
  int flt      = 0;
  int err_seen = 0;
  int exp_cnt  = 0;
  int e0       = 0;

  receptor_sync #(
    .H_DISP (H_DISP), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_DISP (V_DISP), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) dut (
    .CLK_pix_rate (clk),
    .reset        (reset),
    .h_sync_in    (h_sync_in),
    .v_sync_in    (v_sync_in),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .video_on     (video_on),
    .locked       (locked),
    .frame_start  (frame_start),
    .err          (err),
    .err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Drive the sync levels for raster position (bx,by), clock once, sample 1 after the edge
  task automatic drive1();
    logic hs;
    logic vs;
    hs = !(bx >= H_SS && bx < H_SS + H_SYNC);
    vs = !(by >= V_SS && by < V_SS + V_SYNC);
    if (flt == F_HSHIFT) hs = !(bx >= H_SS + 1 && bx < H_SS + H_SYNC);
    if (flt == F_HOMIT)  hs = 1'b1;
    if (flt == F_VLONG)  vs = !(by >= V_SS && by < V_SS + V_SYNC + 1);
    h_sync_in = hs;
    v_sync_in = vs;
    @(posedge clk);
    #1;
    lx = bx;
    ly = by;
    if (err === 1'b1) err_seen++;
    if (bx == H_TOTAL - 1) begin
      bx = 0;
      if (flt == F_HSHIFT || flt == F_HOMIT) flt = F_NONE;
      if (by == V_TOTAL - 1) begin
        by = 0;
        if (flt == F_VLONG) flt = F_NONE;
      end else begin
        by++;
      end
    end else begin
      bx++;
    end
  endtask

  // Drive the stream until (x,y) is the next position to be driven
  task automatic goto(input int x, input int y);
    int n;
    n = 0;
    while (!(bx == x && by == y) && n < 2 * H_TOTAL * V_TOTAL) begin
      drive1();
      n++;
    end
  endtask

  // First vsync moves to CHECK (not locked yet), the next clean vsync locks
  task automatic relock(input string tag);
    goto(0, V_SS);
    drive1();
    chk({tag, "_locked_after_first_vfall"}, locked, 1'b0);
    goto(0, V_SS);
    chk({tag, "_locked_before_second_vfall"}, locked, 1'b0);
    drive1();
    chk({tag, "_locked_after_second_vfall"}, locked, 1'b1);
  endtask

  initial begin
    reset     = 1'b0;
    h_sync_in = 1'b1;
    v_sync_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pixel_x", pixel_x, 0);
    chk("rst_pixel_y", pixel_y, 0);
    chk("rst_video_on", video_on, 0);
    chk("rst_locked", locked, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_err", err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    reset = 1'b1;

    // Ideal stream: lock on the second vsync fall
    relock("t1");

    // One full locked frame: coordinates trail the driver by one cycle
    repeat (H_TOTAL * V_TOTAL) begin
      drive1();
      chk("t1_pixel_x", pixel_x, lx);
      chk("t1_pixel_y", pixel_y, ly);
      chk("t1_video_on", video_on, (lx < H_DISP && ly < V_DISP));
      chk("t1_frame_start", frame_start, (lx == 0 && ly == 0));
      chk("t1_err", err, 0);
      chk("t1_locked", locked, 1);
    end
    chk("t1_err_cnt", err_cnt, 0);

    // Hsync starting one column late on line 1
    goto(0, 1);
    flt = F_HSHIFT;
    repeat (H_SS + 1) drive1();
    chk("t2_err_before", err, 0);
    drive1();
    exp_cnt++;
    chk("t2_err", err, 1);
    chk("t2_err_cnt", err_cnt, exp_cnt);
    chk("t2_locked", locked, 0);
    chk("t2_video_on", video_on, 0);
    drive1();
    chk("t2_err_one_cycle", err, 0);
    relock("t2");
    goto(0, 0);
    drive1();
    chk("t2_frame_start_after_relock", frame_start, 1);

    // Hsync omitted on line 1: caught when the counter reaches the sync start
    goto(0, 1);
    flt = F_HOMIT;
    repeat (H_SS + 1) drive1();
    chk("t3_err_before", err, 0);
    drive1();
    exp_cnt++;
    chk("t3_err", err, 1);
    chk("t3_err_cnt", err_cnt, exp_cnt);
    chk("t3_locked", locked, 0);
    chk("t3_pixel_x", pixel_x, H_SS + 1);
    relock("t3");

    // Vsync held low for three lines
    goto(0, V_SS);
    flt = F_VLONG;
    e0 = err_seen;
    goto(0, V_SS + V_SYNC);
    chk("t4_no_err_during_sync", err_seen - e0, 0);
    chk("t4_locked_during_sync", locked, 1);
    drive1();
    chk("t4_err_at_x0", err, 0);
    chk("t4_pixel_x_0", pixel_x, 0);
    chk("t4_pixel_y_0", pixel_y, V_SS + V_SYNC);
    drive1();
    exp_cnt++;
    chk("t4_err", err, 1);
    chk("t4_pixel_x_1", pixel_x, 1);
    chk("t4_pixel_y_1", pixel_y, V_SS + V_SYNC);
    chk("t4_err_cnt", err_cnt, exp_cnt);
    chk("t4_locked", locked, 0);
    relock("t4");

    // Asynchronous reset in the middle of a locked line
    goto(3, 2);
    reset = 1'b0;
    #1;
    chk("t5_pixel_x", pixel_x, 0);
    chk("t5_pixel_y", pixel_y, 0);
    chk("t5_video_on", video_on, 0);
    chk("t5_locked", locked, 0);
    chk("t5_frame_start", frame_start, 0);
    chk("t5_err", err, 0);
    chk("t5_err_cnt", err_cnt, 0);
    drive1();
    chk("t5_held_pixel_x", pixel_x, 0);
    chk("t5_held_locked", locked, 0);
    reset = 1'b1;
    exp_cnt = 0;
    relock("t5");
    chk("t5_err_cnt_after_relock", err_cnt, 0);

    // 300 violations from LOCKED: count must stop at 255
    e0 = err_seen;
    for (int i = 0; i < 300; i++) begin
      goto(0, 1);
      flt = F_HOMIT;
      repeat (H_SS + 2) drive1();
      if (exp_cnt < 255) exp_cnt++;
      chk("t6_err", err, 1);
      chk("t6_err_cnt", err_cnt, exp_cnt);
      relock("t6");
    end
    chk("t6_err_cnt_saturated", err_cnt, 255);
    chk("t6_err_pulses", err_seen - e0, 300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
